serial_adder: RTL

Multi-cycle, parametrised ripple adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock and holds the carry in a register between digits. It extends the lab's single-bit full adder into a reusable arithmetic unit with valid/ready handshakes on input and output. It sits between a register-file or FSM source and any consumer that can tolerate a WIDTH/DIGIT-cycle latency in exchange for a narrow adder.

---
 rtl/serial_adder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder - digit-serial adder/subtractor with valid/ready handshakes
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NUM  = WIDTH / DIGIT;
  localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_carry;
  logic             msb_carry_in;
  logic             accept;
  logic             last_digit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (idx == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && in_valid;
  assign last_digit = (state == BUSY) && (idx == LAST);

  assign a_dig = a_reg[idx*DIGIT +: DIGIT];
  assign b_dig = b_reg[idx*DIGIT +: DIGIT];
  assign {dig_carry, dig_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};

  // Carry into the top bit of a digit is recovered from that bit's sum.
  assign msb_carry_in = dig_sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? 1'b1 : carry_in;
      idx   <= '0;
    end else if (state == BUSY) begin
      sum[idx*DIGIT +: DIGIT] <= dig_sum;
      carry                   <= dig_carry;
      if (last_digit) begin
        carry_out <= dig_carry;
        overflow  <= msb_carry_in ^ dig_carry;
        idx       <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
